// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer_pkg
//  Brief    : Shared widths, ROB entry record and mispredict helper.
//  Revision : 1.0  initial release
// ============================================================================
package reorder_buffer_pkg;

   localparam int ROB_TAG_WIDTH = 4;
   localparam int REG_TAG_WIDTH = 5;
   localparam int DATA_WIDTH    = 32;
   localparam logic [ROB_TAG_WIDTH-1:0] ZERO_TAG_ROB = '0;

   typedef struct packed {
      logic                     valid;
      logic                     ready;
      logic [REG_TAG_WIDTH-1:0] dest;
      logic                     is_branch;
      logic                     pred;
      logic [DATA_WIDTH-1:0]    pc;
      logic [DATA_WIDTH-1:0]    value;
      logic                     taken;
      logic [DATA_WIDTH-1:0]    target;
   } rob_entry_t;

   // A branch whose resolved direction differs from the fetcher's guess.
   function automatic logic is_mispredict(input rob_entry_t e);
      return e.is_branch && (e.taken != e.pred);
   endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer_if
//  Brief    : Decoder/CDB/register-file side bundle of the reorder buffer.
//             Perf counter outputs exist only with ROB_PERF_CNT_EN defined.
//  Revision : 1.0  initial release
// ============================================================================
interface reorder_buffer_if
   import reorder_buffer_pkg::*;
#(
   parameter int TAG_W = ROB_TAG_WIDTH
);
   logic                     in_alloc_ce;
   logic [REG_TAG_WIDTH-1:0] in_alloc_dest_reg;
   logic                     in_alloc_is_branch;
   logic                     in_alloc_pred_taken;
   logic [DATA_WIDTH-1:0]    in_alloc_pc;
   logic [TAG_W-1:0]         out_alloc_tag;
   logic                     out_full;

   logic                     in_cdb_valid;
   logic [TAG_W-1:0]         in_cdb_tag;
   logic [DATA_WIDTH-1:0]    in_cdb_value;
   logic                     in_cdb_taken;
   logic [DATA_WIDTH-1:0]    in_cdb_target;

   logic [TAG_W-1:0]         in_query_tag1;
   logic [TAG_W-1:0]         in_query_tag2;
   logic                     out_query_ready1;
   logic                     out_query_ready2;
   logic [DATA_WIDTH-1:0]    out_query_value1;
   logic [DATA_WIDTH-1:0]    out_query_value2;

   logic [REG_TAG_WIDTH-1:0] out_reg_commit_reg;
   logic [TAG_W-1:0]         out_reg_commit_rob;
   logic [DATA_WIDTH-1:0]    out_reg_commit_value;
   logic                     out_misbranch;
   logic [DATA_WIDTH-1:0]    out_misbranch_pc;
`ifdef ROB_PERF_CNT_EN
   logic [31:0]              out_commit_cnt;
   logic [31:0]              out_misbranch_cnt;
`endif

   modport master (
`ifdef ROB_PERF_CNT_EN
      input  out_commit_cnt, out_misbranch_cnt,
`endif
      output in_alloc_ce, in_alloc_dest_reg, in_alloc_is_branch, in_alloc_pred_taken, in_alloc_pc,
      input  out_alloc_tag, out_full,
      output in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_taken, in_cdb_target,
      output in_query_tag1, in_query_tag2,
      input  out_query_ready1, out_query_ready2, out_query_value1, out_query_value2,
      input  out_reg_commit_reg, out_reg_commit_rob, out_reg_commit_value,
      input  out_misbranch, out_misbranch_pc
   );

   modport slave (
`ifdef ROB_PERF_CNT_EN
      output out_commit_cnt, out_misbranch_cnt,
`endif
      input  in_alloc_ce, in_alloc_dest_reg, in_alloc_is_branch, in_alloc_pred_taken, in_alloc_pc,
      output out_alloc_tag, out_full,
      input  in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_taken, in_cdb_target,
      input  in_query_tag1, in_query_tag2,
      output out_query_ready1, out_query_ready2, out_query_value1, out_query_value2,
      output out_reg_commit_reg, out_reg_commit_rob, out_reg_commit_value,
      output out_misbranch, out_misbranch_pc
   );
endinterface
`default_nettype wire

// File: rtl/reorder_buffer_query.sv
`default_nettype none
// ============================================================================
//  Module   : rob_query_port
//  Brief    : Operand lookup for the decoder with same-cycle CDB bypass.
//  Revision : 1.0  initial release
// ============================================================================
module rob_query_port
   import reorder_buffer_pkg::*;
#(
   parameter int TAG_W = ROB_TAG_WIDTH
) (
   input  wire logic [TAG_W-1:0]      query_tag,
   input  wire logic                  entry_valid,
   input  wire logic                  entry_ready,
   input  wire logic [DATA_WIDTH-1:0] entry_value,
   input  wire logic                  cdb_valid,
   input  wire logic [TAG_W-1:0]      cdb_tag,
   input  wire logic [DATA_WIDTH-1:0] cdb_value,
   output logic                       ready,
   output logic [DATA_WIDTH-1:0]      value
);
   logic cdb_match;

   // Value is available if already stored or on the CDB right now; the CDB copy wins.
   always_comb begin
      cdb_match = cdb_valid && (cdb_tag == query_tag);
      ready     = (entry_valid && entry_ready) || cdb_match;
      value     = cdb_match ? cdb_value : entry_value;
   end
endmodule
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer
//  Brief    : Circular in-order retirement queue (ROB tag = entry index).
//             Allocates at tail, captures CDB results, commits from head one
//             entry per cycle and raises a one-cycle flush on a mispredict.
//             Optional: ROB_PERF_CNT_EN adds commit / misbranch counters.
//  Revision : 1.0  initial release
// ============================================================================
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int ROB_SIZE = 16,
   parameter int TAG_W    = ROB_TAG_WIDTH
) (
   input wire logic        clk,
   input wire logic        rst,
   input wire logic        rdy,
   reorder_buffer_if.slave bus
);
   localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(ROB_SIZE);
   localparam logic [TAG_W:0]   CNT_ONE    = (TAG_W+1)'(1);
   localparam logic [TAG_W-1:0] TAG_ONE    = TAG_W'(1);

   rob_entry_t       entries [ROB_SIZE];
   logic [TAG_W-1:0] head;
   logic [TAG_W-1:0] tail;
   logic [TAG_W:0]   count;

   rob_entry_t head_entry;
   rob_entry_t q1_entry;
   rob_entry_t q2_entry;
   logic       full;
   logic       alloc_fire;
   logic       commit_fire;
   logic       flush;
   logic       cdb_hit;

   // Decode this cycle's events from the pre-edge state.
   always_comb begin
      head_entry  = entries[head];
      q1_entry    = entries[bus.in_query_tag1];
      q2_entry    = entries[bus.in_query_tag2];
      full        = (count == FULL_COUNT);
      alloc_fire  = bus.in_alloc_ce && !full;
      commit_fire = head_entry.valid && head_entry.ready;
      flush       = commit_fire && is_mispredict(head_entry);
      cdb_hit     = bus.in_cdb_valid && entries[bus.in_cdb_tag].valid;
   end

   assign bus.out_full      = full;
   assign bus.out_alloc_tag = tail;

   // Head/tail/occupancy; a flush overrides any same-cycle alloc or commit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= ZERO_TAG_ROB;
         tail  <= ZERO_TAG_ROB;
         count <= '0;
      end else if (rdy) begin
         if (flush) begin
            head  <= ZERO_TAG_ROB;
            tail  <= ZERO_TAG_ROB;
            count <= '0;
         end else begin
            if (alloc_fire)
               tail <= tail + TAG_ONE;
            if (commit_fire)
               head <= head + TAG_ONE;
            if (alloc_fire && !commit_fire)
               count <= count + CNT_ONE;
            else if (!alloc_fire && commit_fire)
               count <= count - CNT_ONE;
         end
      end
   end

   // Entry storage: flush beats CDB capture, which beats allocation; commit frees the head.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ROB_SIZE; i++)
            entries[i] <= '0;
      end else if (rdy) begin
         if (flush) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
               entries[i].valid <= 1'b0;
               entries[i].ready <= 1'b0;
            end
         end else begin
            if (alloc_fire)
               entries[tail] <= '{valid:     1'b1,
                                  ready:     1'b0,
                                  dest:      bus.in_alloc_dest_reg,
                                  is_branch: bus.in_alloc_is_branch,
                                  pred:      bus.in_alloc_pred_taken,
                                  pc:        bus.in_alloc_pc,
                                  value:     '0,
                                  taken:     1'b0,
                                  target:    '0};
            if (cdb_hit) begin
               entries[bus.in_cdb_tag].ready  <= 1'b1;
               entries[bus.in_cdb_tag].value  <= bus.in_cdb_value;
               entries[bus.in_cdb_tag].taken  <= bus.in_cdb_taken;
               entries[bus.in_cdb_tag].target <= bus.in_cdb_target;
            end
            if (commit_fire) begin
               entries[head].valid <= 1'b0;
               entries[head].ready <= 1'b0;
            end
         end
      end
   end

   // Register-file commit port and redirect; held while rdy is low so nothing is consumed twice.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.out_reg_commit_reg   <= '0;
         bus.out_reg_commit_rob   <= '0;
         bus.out_reg_commit_value <= '0;
         bus.out_misbranch        <= 1'b0;
         bus.out_misbranch_pc     <= '0;
      end else if (rdy) begin
         if (commit_fire) begin
            bus.out_reg_commit_reg   <= head_entry.dest;
            bus.out_reg_commit_rob   <= head;
            bus.out_reg_commit_value <= head_entry.value;
         end else begin
            bus.out_reg_commit_reg   <= '0;
         end
         bus.out_misbranch <= flush;
         if (flush)
            bus.out_misbranch_pc <= head_entry.taken ? head_entry.target
                                                     : head_entry.pc + 32'd4;
      end
   end

   rob_query_port #(.TAG_W(TAG_W)) u_query1 (
      .query_tag   (bus.in_query_tag1),
      .entry_valid (q1_entry.valid),
      .entry_ready (q1_entry.ready),
      .entry_value (q1_entry.value),
      .cdb_valid   (bus.in_cdb_valid),
      .cdb_tag     (bus.in_cdb_tag),
      .cdb_value   (bus.in_cdb_value),
      .ready       (bus.out_query_ready1),
      .value       (bus.out_query_value1)
   );

   rob_query_port #(.TAG_W(TAG_W)) u_query2 (
      .query_tag   (bus.in_query_tag2),
      .entry_valid (q2_entry.valid),
      .entry_ready (q2_entry.ready),
      .entry_value (q2_entry.value),
      .cdb_valid   (bus.in_cdb_valid),
      .cdb_tag     (bus.in_cdb_tag),
      .cdb_value   (bus.in_cdb_value),
      .ready       (bus.out_query_ready2),
      .value       (bus.out_query_value2)
   );

`ifdef ROB_PERF_CNT_EN
   logic [31:0] commit_cnt;
   logic [31:0] misbranch_cnt;

   // Free-running, wrapping event counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         commit_cnt    <= '0;
         misbranch_cnt <= '0;
      end else if (rdy) begin
         if (commit_fire)
            commit_cnt <= commit_cnt + 32'd1;
         if (flush)
            misbranch_cnt <= misbranch_cnt + 32'd1;
      end
   end

   assign bus.out_commit_cnt    = commit_cnt;
   assign bus.out_misbranch_cnt = misbranch_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reorder_buffer
//  Brief    : Self-checking bench for reorder_buffer against a queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reorder_buffer;

   logic clk = 1'b0;
   logic rst;
   logic rdy;

   always #5 clk = ~clk;

   reorder_buffer_if bus ();

   reorder_buffer #(.ROB_SIZE(16), .TAG_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Model: program-order queue of live tags plus per-tag records.
   int          q[$];
   int          next_tag;
   bit          m_valid [16];
   bit          m_ready [16];
   bit          m_br    [16];
   bit          m_pred  [16];
   bit          m_taken [16];
   logic [4:0]  m_dest  [16];
   logic [31:0] m_pc    [16];
   logic [31:0] m_value [16];
   logic [31:0] m_target[16];
   logic [4:0]  e_reg;
   logic [3:0]  e_rob;
   logic [31:0] e_val;
   logic        e_mb;
   logic [31:0] e_mbpc;

   // Comb outputs sampled by the most recent cycle().
   logic        s_r1, s_r2;
   logic [31:0] s_v1, s_v2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      next_tag = 0;
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 0;
         m_ready[i] = 0;
      end
      e_reg = '0; e_rob = '0; e_val = '0; e_mb = 1'b0; e_mbpc = '0;
   endtask

   function automatic void qexp(input int t, output logic r, output logic [31:0] v);
      bit hit;
      hit = bus.in_cdb_valid && (int'(bus.in_cdb_tag) == t);
      r   = (m_valid[t] && m_ready[t]) || hit;
      v   = hit ? bus.in_cdb_value : m_value[t];
   endfunction

   task automatic model_edge();
      int t;
      int ct;
      bit commit;
      bit mis;
      bit full_pre;
      full_pre = (q.size() == 16);
      commit   = (q.size() > 0) && m_ready[q[0]];
      mis      = 0;
      t        = 0;
      if (commit) begin
         t     = q[0];
         e_reg = m_dest[t];
         e_rob = 4'(t);
         e_val = m_value[t];
         mis   = m_br[t] && (m_taken[t] != m_pred[t]);
         if (mis)
            e_mbpc = m_taken[t] ? m_target[t] : m_pc[t] + 32'd4;
      end else begin
         e_reg = '0;
      end
      e_mb = mis;
      if (mis) begin
         q.delete();
         next_tag = 0;
         for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_ready[i] = 0;
         end
      end else begin
         if (bus.in_cdb_valid) begin
            ct = int'(bus.in_cdb_tag);
            if (m_valid[ct]) begin
               m_ready[ct]  = 1;
               m_value[ct]  = bus.in_cdb_value;
               m_taken[ct]  = bus.in_cdb_taken;
               m_target[ct] = bus.in_cdb_target;
            end
         end
         if (commit) begin
            m_valid[t] = 0;
            m_ready[t] = 0;
            void'(q.pop_front());
         end
         if (bus.in_alloc_ce && !full_pre) begin
            t           = next_tag;
            m_valid[t]  = 1;
            m_ready[t]  = 0;
            m_dest[t]   = bus.in_alloc_dest_reg;
            m_br[t]     = bus.in_alloc_is_branch;
            m_pred[t]   = bus.in_alloc_pred_taken;
            m_pc[t]     = bus.in_alloc_pc;
            q.push_back(t);
            next_tag    = (next_tag + 1) % 16;
         end
      end
   endtask

   // One clock: check comb outputs at the falling edge, advance the model, check registers after the rising edge.
   task automatic cycle();
      logic        er;
      logic [31:0] ev;
      @(negedge clk);
      s_r1 = bus.out_query_ready1; s_v1 = bus.out_query_value1;
      s_r2 = bus.out_query_ready2; s_v2 = bus.out_query_value2;
      chk("full", 32'(bus.out_full), 32'(q.size() == 16));
      chk("alloc_tag", 32'(bus.out_alloc_tag), 32'(next_tag));
      qexp(int'(bus.in_query_tag1), er, ev);
      chk("q1_ready", 32'(s_r1), 32'(er));
      if (er) chk("q1_value", s_v1, ev);
      qexp(int'(bus.in_query_tag2), er, ev);
      chk("q2_ready", 32'(s_r2), 32'(er));
      if (er) chk("q2_value", s_v2, ev);
      if (rdy) model_edge();
      @(posedge clk);
      #1;
      chk("commit_reg", 32'(bus.out_reg_commit_reg), 32'(e_reg));
      chk("commit_rob", 32'(bus.out_reg_commit_rob), 32'(e_rob));
      chk("commit_value", bus.out_reg_commit_value, e_val);
      chk("misbranch", 32'(bus.out_misbranch), 32'(e_mb));
      chk("misbranch_pc", bus.out_misbranch_pc, e_mbpc);
   endtask

   task automatic idle();
      rdy = 1'b1;
      bus.in_alloc_ce = 1'b0; bus.in_alloc_dest_reg = '0; bus.in_alloc_is_branch = 1'b0;
      bus.in_alloc_pred_taken = 1'b0; bus.in_alloc_pc = '0;
      bus.in_cdb_valid = 1'b0; bus.in_cdb_tag = '0; bus.in_cdb_value = '0;
      bus.in_cdb_taken = 1'b0; bus.in_cdb_target = '0;
      bus.in_query_tag1 = '0; bus.in_query_tag2 = '0;
   endtask

   task automatic zero_outputs(input string tag);
      chk({tag, "_commit_reg"}, 32'(bus.out_reg_commit_reg), 0);
      chk({tag, "_commit_rob"}, 32'(bus.out_reg_commit_rob), 0);
      chk({tag, "_commit_value"}, bus.out_reg_commit_value, 0);
      chk({tag, "_misbranch"}, 32'(bus.out_misbranch), 0);
      chk({tag, "_misbranch_pc"}, bus.out_misbranch_pc, 0);
      chk({tag, "_full"}, 32'(bus.out_full), 0);
      chk({tag, "_alloc_tag"}, 32'(bus.out_alloc_tag), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst = 1'b0;
      #1;
      zero_outputs("reset");
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic alloc(input logic [4:0] d, input logic br, input logic pr, input logic [31:0] pc);
      idle();
      bus.in_alloc_ce = 1'b1; bus.in_alloc_dest_reg = d; bus.in_alloc_is_branch = br;
      bus.in_alloc_pred_taken = pr; bus.in_alloc_pc = pc;
      cycle();
   endtask

   task automatic cdb(input logic [3:0] t, input logic [31:0] v, input logic tk, input logic [31:0] tg);
      idle();
      bus.in_cdb_valid = 1'b1; bus.in_cdb_tag = t; bus.in_cdb_value = v;
      bus.in_cdb_taken = tk; bus.in_cdb_target = tg;
      cycle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      idle();
      model_reset();

      // In-order retirement of out-of-order completions.
      do_reset();
      alloc(5'd1, 0, 0, 32'h0); alloc(5'd2, 0, 0, 32'h4); alloc(5'd3, 0, 0, 32'h8);
      cdb(4'd2, 32'h30, 0, 0); cdb(4'd0, 32'h10, 0, 0); cdb(4'd1, 32'h20, 0, 0);
      chk("lit_c1_reg", 32'(bus.out_reg_commit_reg), 1);
      chk("lit_c1_rob", 32'(bus.out_reg_commit_rob), 0);
      chk("lit_c1_val", bus.out_reg_commit_value, 32'h10);
      idle(); cycle();
      chk("lit_c2_reg", 32'(bus.out_reg_commit_reg), 2);
      chk("lit_c2_rob", 32'(bus.out_reg_commit_rob), 1);
      idle(); cycle();
      chk("lit_c3_reg", 32'(bus.out_reg_commit_reg), 3);
      chk("lit_c3_rob", 32'(bus.out_reg_commit_rob), 2);
      idle(); cycle();
      chk("lit_c4_reg", 32'(bus.out_reg_commit_reg), 0);

      // Fill, drop on full, free one slot, wrap-around allocation.
      do_reset();
      for (int i = 0; i < 16; i++) alloc(5'(i + 1), 0, 0, 32'(i * 4));
      chk("lit_full16", 32'(bus.out_full), 1);
      chk("lit_tag_wrap", 32'(bus.out_alloc_tag), 0);
      alloc(5'd7, 0, 0, 32'h40);
      chk("lit_drop_full", 32'(bus.out_full), 1);
      chk("lit_drop_tag", 32'(bus.out_alloc_tag), 0);
      cdb(4'd0, 32'h55, 0, 0);
      chk("lit_full_ready", 32'(bus.out_full), 1);
      idle(); cycle();
      chk("lit_freed", 32'(bus.out_full), 0);
      alloc(5'd9, 0, 0, 32'h44);
      chk("lit_wrap_alloc_tag", 32'(bus.out_alloc_tag), 1);
      chk("lit_wrap_full", 32'(bus.out_full), 1);

      // Mispredicted JAL: flush, redirect, same-edge alloc dropped.
      do_reset();
      alloc(5'd1, 1, 0, 32'h100); alloc(5'd2, 0, 0, 32'h104);
      cdb(4'd0, 32'h104, 1, 32'h200);
      alloc(5'd5, 0, 0, 32'h108);
      chk("lit_mb", 32'(bus.out_misbranch), 1);
      chk("lit_mb_pc", bus.out_misbranch_pc, 32'h200);
      chk("lit_mb_reg", 32'(bus.out_reg_commit_reg), 1);
      chk("lit_mb_val", bus.out_reg_commit_value, 32'h104);
      chk("lit_mb_tag", 32'(bus.out_alloc_tag), 0);
      idle(); cycle();
      chk("lit_mb_pulse_end", 32'(bus.out_misbranch), 0);
      chk("lit_mb_no_commit", 32'(bus.out_reg_commit_reg), 0);

      // Query bypass from the CDB.
      do_reset();
      for (int i = 0; i < 6; i++) alloc(5'(i + 1), 0, 0, 32'(i * 4));
      idle();
      bus.in_cdb_valid = 1'b1; bus.in_cdb_tag = 4'd5; bus.in_cdb_value = 32'hDEAD;
      bus.in_query_tag1 = 4'd5; bus.in_query_tag2 = 4'd9;
      cycle();
      chk("lit_q_bypass_ready", 32'(s_r1), 1);
      chk("lit_q_bypass_value", s_v1, 32'hDEAD);
      chk("lit_q_unalloc_ready", 32'(s_r2), 0);

      // rdy low freezes everything, commit consumed exactly once.
      do_reset();
      alloc(5'd4, 0, 0, 32'h0); alloc(5'd5, 0, 0, 32'h4);
      cdb(4'd0, 32'hA0, 0, 0); cdb(4'd1, 32'hB0, 0, 0);
      chk("lit_rdy_first", 32'(bus.out_reg_commit_reg), 4);
      for (int i = 0; i < 3; i++) begin
         idle(); rdy = 1'b0;
         bus.in_alloc_ce = 1'b1; bus.in_alloc_dest_reg = 5'd9;
         cycle();
         chk("lit_rdy_hold_reg", 32'(bus.out_reg_commit_reg), 4);
         chk("lit_rdy_hold_tag", 32'(bus.out_alloc_tag), 2);
      end
      idle(); cycle();
      chk("lit_rdy_next_reg", 32'(bus.out_reg_commit_reg), 5);
      chk("lit_rdy_next_rob", 32'(bus.out_reg_commit_rob), 1);
      idle(); cycle();
      chk("lit_rdy_no_dup", 32'(bus.out_reg_commit_reg), 0);

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         idle();
         rdy = ($urandom_range(0, 99) < 85);
         if ($urandom_range(0, 99) < 55) begin
            bus.in_alloc_ce         = 1'b1;
            bus.in_alloc_dest_reg   = 5'($urandom_range(0, 31));
            bus.in_alloc_is_branch  = ($urandom_range(0, 99) < 12);
            bus.in_alloc_pred_taken = bus.in_alloc_is_branch ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.in_alloc_pc         = $urandom() & 32'hFFFF_FFFC;
         end
         if ($urandom_range(0, 99) < 45) begin
            bus.in_cdb_valid  = 1'b1;
            if (q.size() > 0 && $urandom_range(0, 99) < 80)
               bus.in_cdb_tag = 4'(q[$urandom_range(0, q.size() - 1)]);
            else
               bus.in_cdb_tag = 4'($urandom_range(0, 15));
            bus.in_cdb_value  = $urandom();
            bus.in_cdb_taken  = 1'($urandom_range(0, 1));
            bus.in_cdb_target = $urandom() & 32'hFFFF_FFFC;
         end
         if (q.size() > 0 && $urandom_range(0, 1) == 1)
            bus.in_query_tag1 = 4'(q[$urandom_range(0, q.size() - 1)]);
         else
            bus.in_query_tag1 = 4'($urandom_range(0, 15));
         bus.in_query_tag2 = 4'($urandom_range(0, 15));
         cycle();
      end

      // Asynchronous reset during a misbranch pulse.
      do_reset();
      alloc(5'd1, 1, 0, 32'h300);
      cdb(4'd0, 32'h304, 1, 32'h400);
      idle(); cycle();
      chk("lit_async_pulse", 32'(bus.out_misbranch), 1);
      chk("lit_async_pc", bus.out_misbranch_pc, 32'h400);
      rst = 1'b0;
      #1;
      zero_outputs("async");
      model_reset();
      @(negedge clk);
      rst = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
